snake_ring_engine: RTL and testbench

Game-state engine for the 4-LED compass ring (N, E, S, W) plus centre LED.
- Moves a "snake" of 1-3 lit segments around the ring at a prescaled rate, with direction, pause and length control.
- Sits directly upstream of the top-level LED pin assignments. Its registered ring/centre outputs drive LED_N/E/S/W/CENTRE with no further logic.
- Replaces the free-running single-LED rotation with a controllable sequencer.

---
 rtl/snake_pkg.sv | 18 +
 rtl/tick_divider.sv | 16 +
 rtl/snake_ring_engine.sv | 50 +++++
 tb/tb_snake_ring_engine.sv | 115 +++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared constants, state encoding and ring-mask helper for the snake ring engine
package snake_pkg;
  localparam logic [1:0] IDX_N = 2'd0;
  localparam logic [1:0] IDX_E = 2'd1;
  localparam logic [1:0] IDX_S = 2'd2;
  localparam logic [1:0] IDX_W = 2'd3;
  localparam int LEN_MIN = 1;
  localparam int LEN_MAX = 3;
  typedef enum logic {ST_RUN, ST_PAUSED} state_t;
  // Body segments trail the head, opposite to the direction of travel.
  function automatic logic [3:0] ring_mask(input logic [1:0] head, input logic [1:0] len, input logic cw);
    logic [1:0] t1;
    logic [1:0] t2;
    t1 = cw ? head - 2'd1 : head + 2'd1;
    t2 = cw ? head - 2'd2 : head + 2'd2;
    return (4'b0001 << head) | (len >= 2'd2 ? 4'b0001 << t1 : 4'b0000) | (len == 2'(LEN_MAX) ? 4'b0001 << t2 : 4'b0000);
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running prescaler, one-cycle tick every DIV_MAX+1 clocks
module tick_divider #(
  parameter int DIV_MAX = 1000000,
  parameter int DIV_W   = 24
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [DIV_W-1:0] div;
  assign tick = div == DIV_W'(DIV_MAX);
  always_ff @(posedge clk) begin
    if (rst) div <= '0;
    else div <= tick ? '0 : div + 1'b1;
  end
endmodule

// File: rtl/snake_ring_engine.sv
// snake_ring_engine: moves a 1-3 segment snake around the N/E/S/W LED ring with pause/direction/length control
module snake_ring_engine
  import snake_pkg::*;
#(
  parameter int DIV_MAX = 1000000,
  parameter int DIV_W   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       dir_cw,
  input  logic [1:0] len_sel,
  output logic [3:0] ring,
  output logic       centre,
  output logic       step,
  output logic [1:0] head_pos
);
  logic tick;
  state_t state;
  logic [1:0] len_n;
  logic [1:0] head_n;
  tick_divider #(.DIV_MAX(DIV_MAX), .DIV_W(DIV_W)) u_div (.clk(clk), .rst(rst), .tick(tick));
  assign len_n  = len_sel == 2'd0 ? 2'(LEN_MIN) : len_sel;
  assign head_n = dir_cw ? head_pos + 2'd1 : head_pos - 2'd1;
  // Direction and length only live on in the ring image, so they are folded in at the move.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      head_pos <= IDX_N;
      ring     <= 4'b0001;
      centre   <= 1'b1;
      step     <= 1'b0;
    end else begin
      step <= 1'b0;
      if (state == ST_RUN) begin
        if (pause) state <= ST_PAUSED;
        else if (tick) begin
          head_pos <= head_n;
          ring     <= ring_mask(head_n, len_n, dir_cw);
          step     <= 1'b1;
        end
      end else begin
        if (!pause) begin
          state  <= ST_RUN;
          centre <= 1'b1;
        end else if (tick) centre <= ~centre;
      end
    end
  end
endmodule

// File: tb/tb_snake_ring_engine.sv
// tb_snake_ring_engine: scoreboard bench comparing the engine against a behavioural game model
module tb_snake_ring_engine;
  typedef struct packed {
    logic [3:0] ring;
    logic       centre;
    logic       step;
    logic [1:0] head;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pause = 1'b0;
  logic dir_cw = 1'b1;
  logic [1:0] len_sel = 2'd1;
  logic [3:0] ring;
  logic centre, step;
  logic [1:0] head_pos;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int m_div = 0, m_head = 0, m_len = 1;
  bit m_cw = 1, m_paused = 0, m_centre = 1, m_step = 0;
  snake_ring_engine #(.DIV_MAX(3), .DIV_W(2)) dut (
    .clk(clk), .rst(rst), .pause(pause), .dir_cw(dir_cw), .len_sel(len_sel),
    .ring(ring), .centre(centre), .step(step), .head_pos(head_pos)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] model_ring(int h, int l, bit cw);
    logic [3:0] m = '0;
    for (int k = 0; k < l; k++) m[cw ? (h - k + 4) % 4 : (h + k) % 4] = 1'b1;
    return m;
  endfunction
  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ring", int'(ring), int'(e.ring));
      chk("centre", int'(centre), int'(e.centre));
      chk("step", int'(step), int'(e.step));
      chk("head_pos", int'(head_pos), int'(e.head));
    end
  end
  task automatic cyc(bit r, bit p, bit d, logic [1:0] l);
    exp_t e;
    bit tick;
    #1;
    rst = r; pause = p; dir_cw = d; len_sel = l;
    if (r) begin
      m_div = 0; m_head = 0; m_len = 1; m_cw = 1; m_paused = 0; m_centre = 1; m_step = 0;
    end else begin
      tick = (m_div == 3);
      m_div = (m_div + 1) % 4;
      m_step = 0;
      if (!m_paused) begin
        if (p) m_paused = 1;
        else if (tick) begin
          m_cw = d;
          m_len = (l == 0) ? 1 : int'(l);
          m_head = (m_head + (d ? 1 : 3)) % 4;
          m_step = 1;
        end
      end else if (!p) begin
        m_paused = 0;
        m_centre = 1;
      end else if (tick) m_centre = !m_centre;
    end
    e.ring = model_ring(m_head, m_len, m_cw);
    e.centre = m_centre;
    e.step = m_step;
    e.head = 2'(m_head);
    @(posedge clk);
    exp_q.push_back(e);
  endtask
  initial begin
    bit p;
    cyc(1, 0, 1, 1);
    repeat (20) cyc(0, 0, 1, 1);
    cyc(1, 0, 1, 1);
    repeat (8) cyc(0, 0, 0, 3);
    repeat (4) cyc(0, 0, 0, 0);
    repeat (12) cyc(0, 1, 0, 2);
    repeat (8) cyc(0, 0, 1, 2);
    while (m_div != 3) cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    repeat (5) cyc(0, 1, 1, 1);
    repeat (2) cyc(0, 0, 1, 2);
    repeat (3) cyc(0, 0, 0, 2);
    repeat (6) cyc(0, 0, 1, 3);
    cyc(1, 0, 1, 1);
    repeat (8) cyc(0, 0, 1, 3);
    cyc(0, 1, 1, 3);
    while (m_div != 2) cyc(0, 1, 1, 3);
    cyc(1, 1, 1, 3);
    repeat (8) cyc(0, 0, 1, 1);
    cyc(1, 0, 1, 1);
    repeat (16) cyc(0, 0, 1, 2);
    repeat (4) cyc(0, 0, 0, 2);
    p = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) p = !p;
      cyc($urandom_range(99) == 0, p, 1'($urandom), 2'($urandom));
    end
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
